// File: rtl/fadder_half_precision.sv
// Two-stage half-precision (1/5/10) adder/subtractor, fixed latency of two clocks.
// Define FADDER_ROUND_NEAREST_EN for round-to-nearest-even; otherwise results are truncated.
module fadder_half_precision (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic       add,
    input  logic       in_Sign_1,
    input  logic [4:0] in_Exponent_1,
    input  logic [9:0] in_Mantissa_1,
    input  logic       in_Sign_2,
    input  logic [4:0] in_Exponent_2,
    input  logic [9:0] in_Mantissa_2,
    output logic       out_valid,
    output logic       out_Sign,
    output logic [4:0] out_Exponent,
    output logic [9:0] out_Mantissa,
    output logic       Output_OverFlow,
    output logic       Exponent_UnderFlow
);

    // ---------------- stage 1: swap and align ----------------
    logic        a_nz, b_nz, b_sign_eff, a_big, small_nz;
    logic [14:0] mag_a, mag_b;
    logic [10:0] sig_a, sig_b, sig_big, sig_small;
    logic [4:0]  exp_big, exp_small, exp_diff;
    logic        sign_big;
    logic [23:0] shift_win;
    logic [13:0] small_aligned;

    logic        s1_valid_d, s1_valid_q;
    logic        s1_sign_d, s1_sign_q;
    logic        s1_sub_d, s1_sub_q;
    logic [4:0]  s1_exp_d, s1_exp_q;
    logic [13:0] s1_big_d, s1_big_q;
    logic [13:0] s1_small_d, s1_small_q;

    always_comb begin
        a_nz       = |in_Exponent_1;
        b_nz       = |in_Exponent_2;
        mag_a      = a_nz ? {in_Exponent_1, in_Mantissa_1} : 15'd0;
        mag_b      = b_nz ? {in_Exponent_2, in_Mantissa_2} : 15'd0;
        sig_a      = a_nz ? {1'b1, in_Mantissa_1} : 11'd0;
        sig_b      = b_nz ? {1'b1, in_Mantissa_2} : 11'd0;
        b_sign_eff = in_Sign_2 ^ ~add;
        a_big      = (mag_a >= mag_b);

        if (a_big) begin
            exp_big   = in_Exponent_1;
            sig_big   = sig_a;
            sign_big  = in_Sign_1;
            exp_small = in_Exponent_2;
            sig_small = sig_b;
            small_nz  = b_nz;
        end else begin
            exp_big   = in_Exponent_2;
            sig_big   = sig_b;
            sign_big  = b_sign_eff;
            exp_small = in_Exponent_1;
            sig_small = sig_a;
            small_nz  = a_nz;
        end

        // Window holds significand, guard, round and 11 sticky positions.
        exp_diff  = exp_big - exp_small;
        shift_win = {sig_small, 13'd0} >> exp_diff;
        if (exp_diff >= 5'd13) begin
            small_aligned = {13'd0, small_nz};
        end else begin
            small_aligned = {shift_win[23:11], |shift_win[10:0]};
        end

        s1_valid_d = in_valid;
        s1_sign_d  = sign_big;
        s1_sub_d   = in_Sign_1 ^ b_sign_eff;
        s1_exp_d   = exp_big;
        s1_big_d   = {sig_big, 3'b000};
        s1_small_d = small_aligned;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_sign_q  <= 1'b0;
            s1_sub_q   <= 1'b0;
            s1_exp_q   <= 5'd0;
            s1_big_q   <= 14'd0;
            s1_small_q <= 14'd0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_sign_q  <= s1_sign_d;
            s1_sub_q   <= s1_sub_d;
            s1_exp_q   <= s1_exp_d;
            s1_big_q   <= s1_big_d;
            s1_small_q <= s1_small_d;
        end
    end

    // ---------------- stage 2: add/sub, normalize, round ----------------
    logic [14:0]       sum;
    logic [13:0]       norm;
    logic [3:0]        lzc;
    logic              lz_found;
    logic signed [7:0] exp_norm, exp_fin;
    logic              rnd_up;
    logic [11:0]       sig_rnd;
    logic [9:0]        mant_fin;

    logic       res_sign, res_ovf, res_unf;
    logic [4:0] res_exp;
    logic [9:0] res_mant;

    logic       out_valid_d, out_valid_q;
    logic       out_sign_d, out_sign_q;
    logic [4:0] out_exp_d, out_exp_q;
    logic [9:0] out_mant_d, out_mant_q;
    logic       ovf_d, ovf_q, unf_d, unf_q;

`ifdef FADDER_ROUND_NEAREST_EN
    assign rnd_up = norm[2] & (norm[1] | norm[0] | norm[3]);
`else
    logic [2:0] grs_unused;
    assign grs_unused = norm[2:0];
    assign rnd_up     = 1'b0;
`endif

    always_comb begin
        sum = s1_sub_q ? ({1'b0, s1_big_q} - {1'b0, s1_small_q})
                       : ({1'b0, s1_big_q} + {1'b0, s1_small_q});

        lzc      = 4'd0;
        lz_found = 1'b0;
        for (int i = 13; i >= 0; i--) begin
            if (!lz_found) begin
                if (sum[i]) lz_found = 1'b1;
                else        lzc = lzc + 4'd1;
            end
        end

        // A carry-out folds the dropped LSB into sticky.
        if (sum[14]) begin
            norm     = {sum[14:2], sum[1] | sum[0]};
            exp_norm = $signed({3'b000, s1_exp_q}) + 8'sd1;
        end else begin
            norm     = sum[13:0] << lzc;
            exp_norm = $signed({3'b000, s1_exp_q}) - $signed({4'b0000, lzc});
        end

        sig_rnd = {1'b0, norm[13:3]} + {11'd0, rnd_up};
        if (sig_rnd[11]) begin
            exp_fin  = exp_norm + 8'sd1;
            mant_fin = sig_rnd[10:1];
        end else begin
            exp_fin  = exp_norm;
            mant_fin = sig_rnd[9:0];
        end

        res_sign = s1_sign_q;
        res_exp  = exp_fin[4:0];
        res_mant = mant_fin;
        res_ovf  = 1'b0;
        res_unf  = 1'b0;
        if (sum == 15'd0) begin
            // Cancellation gives +0; two like-signed zeros keep their sign.
            res_sign = s1_sub_q ? 1'b0 : s1_sign_q;
            res_exp  = 5'd0;
            res_mant = 10'd0;
        end else if (exp_fin > 8'sd30) begin
            res_exp  = 5'd31;
            res_mant = 10'd0;
            res_ovf  = 1'b1;
        end else if (exp_fin < 8'sd1) begin
            res_exp  = 5'd0;
            res_mant = 10'd0;
            res_unf  = 1'b1;
        end

        out_valid_d = s1_valid_q;
        out_sign_d  = out_sign_q;
        out_exp_d   = out_exp_q;
        out_mant_d  = out_mant_q;
        ovf_d       = ovf_q;
        unf_d       = unf_q;
        if (s1_valid_q) begin
            out_sign_d = res_sign;
            out_exp_d  = res_exp;
            out_mant_d = res_mant;
            ovf_d      = res_ovf;
            unf_d      = res_unf;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_sign_q  <= 1'b0;
            out_exp_q   <= 5'd0;
            out_mant_q  <= 10'd0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_sign_q  <= out_sign_d;
            out_exp_q   <= out_exp_d;
            out_mant_q  <= out_mant_d;
            ovf_q       <= ovf_d;
            unf_q       <= unf_d;
        end
    end

    assign out_valid          = out_valid_q;
    assign out_Sign           = out_sign_q;
    assign out_Exponent       = out_exp_q;
    assign out_Mantissa       = out_mant_q;
    assign Output_OverFlow    = ovf_q;
    assign Exponent_UnderFlow = unf_q;

endmodule

// File: tb/tb_fadder_half_precision.sv
// Bench for fadder_half_precision: exact-integer reference model, per-cycle compare, directed and random stimulus.
module tb_fadder_half_precision;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0, add = 1'b0;
    logic       in_Sign_1 = 1'b0, in_Sign_2 = 1'b0;
    logic [4:0] in_Exponent_1 = 5'd0, in_Exponent_2 = 5'd0;
    logic [9:0] in_Mantissa_1 = 10'd0, in_Mantissa_2 = 10'd0;
    logic       out_valid, out_Sign, Output_OverFlow, Exponent_UnderFlow;
    logic [4:0] out_Exponent;
    logic [9:0] out_Mantissa;

    int errors = 0;
    int checks = 0;

    fadder_half_precision dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .add(add),
        .in_Sign_1(in_Sign_1), .in_Exponent_1(in_Exponent_1), .in_Mantissa_1(in_Mantissa_1),
        .in_Sign_2(in_Sign_2), .in_Exponent_2(in_Exponent_2), .in_Mantissa_2(in_Mantissa_2),
        .out_valid(out_valid), .out_Sign(out_Sign), .out_Exponent(out_Exponent),
        .out_Mantissa(out_Mantissa), .Output_OverFlow(Output_OverFlow),
        .Exponent_UnderFlow(Exponent_UnderFlow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       v;
        logic       s;
        logic [4:0] e;
        logic [9:0] m;
        logic       ovf;
        logic       unf;
    } res_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // Exact value as integer in units of 2^-24, summed as signed integers, then rounded.
    function automatic res_t model(input logic ad, input logic sa, input logic [4:0] ea,
                                   input logic [9:0] fa, input logic sb_in,
                                   input logic [4:0] eb, input logic [9:0] fb);
        res_t   o;
        longint ma, mb, r, mag, sig, rem, half;
        int     p, sh, ex;
        logic   sb;
        o = '0;
        o.v = 1'b1;
        ma = 0;
        mb = 0;
        if (ea != 5'd0) ma = longint'(1024 + int'(fa)) << (int'(ea) - 1);
        if (eb != 5'd0) mb = longint'(1024 + int'(fb)) << (int'(eb) - 1);
        sb = sb_in ^ ~ad;
        r = (sa ? -ma : ma) + (sb ? -mb : mb);
        if (r == 0) begin
            o.s = (sa == sb) ? sa : 1'b0;
            return o;
        end
        o.s = (r < 0);
        mag = (r < 0) ? -r : r;
        p = 0;
        for (int i = 0; i < 63; i++) if (mag[i]) p = i;
        ex = p - 9;
        if (p >= 10) begin
            sh  = p - 10;
            sig = mag >> sh;
            rem = mag - (sig << sh);
`ifdef FADDER_ROUND_NEAREST_EN
            if (sh > 0) begin
                half = longint'(1) << (sh - 1);
                if (rem > half || (rem == half && sig[0])) sig = sig + 1;
            end
`else
            half = rem;
`endif
        end else begin
            sig = mag << (10 - p);
        end
        if (sig == 2048) begin
            sig = 1024;
            ex  = ex + 1;
        end
        if (ex > 30) begin
            o.e = 5'd31;
            o.ovf = 1'b1;
        end else if (ex < 1) begin
            o.unf = 1'b1;
        end else begin
            o.e = ex[4:0];
            o.m = sig[9:0];
        end
        return o;
    endfunction

    res_t pipe0 = '0, pipe1 = '0, last_res = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe0    <= '0;
            pipe1    <= '0;
            last_res <= '0;
        end else begin
            pipe0    <= in_valid ? model(add, in_Sign_1, in_Exponent_1, in_Mantissa_1,
                                         in_Sign_2, in_Exponent_2, in_Mantissa_2) : '0;
            pipe1    <= pipe0;
            last_res <= pipe0.v ? pipe0 : last_res;
        end
    end

    always @(negedge clk) begin
        chk("out_valid", 32'(out_valid), 32'(pipe1.v));
        chk("out_Sign", 32'(out_Sign), 32'(last_res.s));
        chk("out_Exponent", 32'(out_Exponent), 32'(last_res.e));
        chk("out_Mantissa", 32'(out_Mantissa), 32'(last_res.m));
        chk("Output_OverFlow", 32'(Output_OverFlow), 32'(last_res.ovf));
        chk("Exponent_UnderFlow", 32'(Exponent_UnderFlow), 32'(last_res.unf));
    end

    task automatic directed(input string nm, input logic ad,
                            input logic sa, input logic [4:0] ea, input logic [9:0] fa,
                            input logic sb, input logic [4:0] eb, input logic [9:0] fb,
                            input logic [17:0] want);
        res_t r;
        r = model(ad, sa, ea, fa, sb, eb, fb);
        chk({nm, " model"}, 32'({r.s, r.e, r.m, r.ovf, r.unf}), 32'(want));
        @(posedge clk);
        #1;
        in_valid = 1'b1; add = ad;
        in_Sign_1 = sa; in_Exponent_1 = ea; in_Mantissa_1 = fa;
        in_Sign_2 = sb; in_Exponent_2 = eb; in_Mantissa_2 = fb;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk({nm, " valid after 1 edge"}, 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        chk({nm, " valid after 2 edges"}, 32'(out_valid), 32'd1);
        chk({nm, " result"}, 32'({out_Sign, out_Exponent, out_Mantissa, Output_OverFlow,
                                  Exponent_UnderFlow}), 32'(want));
        $display("directed %s: s=%0b e=%05b m=%010b ovf=%0b unf=%0b", nm, out_Sign,
                 out_Exponent, out_Mantissa, Output_OverFlow, Exponent_UnderFlow);
    endtask

    task automatic random_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            in_valid      = ($urandom_range(3) != 0);
            add           = 1'($urandom);
            in_Sign_1     = 1'($urandom);
            in_Sign_2     = 1'($urandom);
            in_Exponent_1 = 5'($urandom);
            in_Mantissa_1 = 10'($urandom);
            in_Mantissa_2 = ($urandom_range(3) == 0) ? in_Mantissa_1 : 10'($urandom);
            case ($urandom_range(5))
                0:       in_Exponent_2 = in_Exponent_1;
                1, 2:    in_Exponent_2 = 5'(int'(in_Exponent_1) + int'($urandom_range(4)) - 2);
                3:       in_Exponent_2 = 5'd0;
                default: in_Exponent_2 = 5'($urandom);
            endcase
            if ($urandom_range(15) == 0) in_Exponent_1 = 5'd0;
        end
    endtask

    logic [17:0] want6;

    initial begin
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        directed("double", 1'b1, 1'b0, 5'b11100, 10'b1110111101, 1'b0, 5'b11100, 10'b1110111101,
                 {1'b0, 5'b11101, 10'b1110111101, 2'b00});
        directed("cancel", 1'b0, 1'b0, 5'b11100, 10'b1110111101, 1'b0, 5'b11100, 10'b1110111101,
                 {1'b0, 5'b00000, 10'b0000000000, 2'b00});
        directed("one_plus_half", 1'b1, 1'b0, 5'b01111, 10'd0, 1'b0, 5'b01110, 10'd0,
                 {1'b0, 5'b01111, 10'b1000000000, 2'b00});
        directed("overflow", 1'b1, 1'b0, 5'b11110, 10'd0, 1'b0, 5'b11110, 10'd0,
                 {1'b0, 5'b11111, 10'd0, 2'b10});
        directed("underflow", 1'b0, 1'b0, 5'b00001, 10'd1, 1'b0, 5'b00001, 10'd0,
                 {1'b0, 5'b00000, 10'd0, 2'b01});
`ifdef FADDER_ROUND_NEAREST_EN
        want6 = {1'b0, 5'b11010, 10'b0000000010, 2'b00};
`else
        want6 = {1'b0, 5'b11010, 10'b0000000001, 2'b00};
`endif
        directed("round_2048_3", 1'b1, 1'b0, 5'b11010, 10'd0, 1'b0, 5'b10000, 10'b1000000000, want6);
        directed("neg_zeros", 1'b1, 1'b1, 5'd0, 10'd5, 1'b1, 5'd0, 10'd0,
                 {1'b1, 5'd0, 10'd0, 2'b00});
        directed("mixed_zeros", 1'b0, 1'b0, 5'd0, 10'd0, 1'b0, 5'd0, 10'd0,
                 {1'b0, 5'd0, 10'd0, 2'b00});

        random_cycles(1500);

        // Reset mid-stream with operations in flight.
        @(posedge clk);
        #1 in_valid = 1'b1;
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset out fields", 32'({out_Sign, out_Exponent, out_Mantissa, Output_OverFlow,
                                     Exponent_UnderFlow}), 32'd0);
        $display("reset mid-stream: out_valid=%0b", out_valid);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        random_cycles(1500);

        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
